// File: rtl/vector_alu_if.sv
// Operand/result bundle for the lane-parallel vector ALU.
// The master drives operands and opcode; the slave returns the registered result.
interface vector_alu_if #(
  parameter int REG_WIDTH  = 256,
  parameter int ELEM_WIDTH = 32
);
  logic [REG_WIDTH-1:0] A;
  logic [REG_WIDTH-1:0] B;
  logic                 UseImm;
  logic [2:0]           ALUControl;
  logic [REG_WIDTH-1:0] Result;
  logic                 Zero;

  modport master (output A, B, UseImm, ALUControl, input Result, Zero);
  modport slave  (input A, B, UseImm, ALUControl, output Result, Zero);
endinterface

// File: rtl/vector_alu.sv
// Lane-parallel SIMD integer ALU: add/sub/repl/mul/shl/slt per ELEM_WIDTH lane,
// result and Zero flag registered with one-cycle latency.
module vector_alu_lane #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] b0,
  input  logic [2:0]   op,
  output logic [W-1:0] y
);
  localparam int SW = $clog2(W);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_REPL = 3'b010;
  localparam logic [2:0] OP_MUL  = 3'b011;
  localparam logic [2:0] OP_SHL  = 3'b100;
  localparam logic [2:0] OP_SLT  = 3'b101;

  logic [W-1:0] prod;
  logic         lt;

  // Low half of the product is sign-agnostic, so one unsigned multiplier serves both.
  assign prod = a * b;
  assign lt   = $signed(a) < $signed(b);

  always_comb begin
    y = '0;
    unique case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_REPL: y = b0;
      OP_MUL:  y = prod;
      OP_SHL:  y = a << b[SW-1:0];
      OP_SLT:  y = {{(W-1){1'b0}}, lt};
      default: y = '0;
    endcase
  end
endmodule

module vector_alu #(
  parameter int NUM_REGS   = 8,
  parameter int REG_WIDTH  = 256,
  parameter int ELEM_WIDTH = 32
) (
  input logic         clk,
  input logic         rst,
  vector_alu_if.slave bus
);
  localparam int LANES = REG_WIDTH / ELEM_WIDTH;

  if (NUM_REGS < 1 || (REG_WIDTH % ELEM_WIDTH) != 0) begin : g_bad_cfg
    $error("vector_alu: invalid NUM_REGS/REG_WIDTH/ELEM_WIDTH");
  end

  logic [LANES-1:0][ELEM_WIDTH-1:0] a_l, b_l, y_l;
  logic [ELEM_WIDTH-1:0]            b0;

  assign a_l = bus.A;
  assign b0  = bus.B[ELEM_WIDTH-1:0];

  // Immediate mode broadcasts lane 0 of B to every lane.
  for (genvar i = 0; i < LANES; i++) begin : g_b
    assign b_l[i] = bus.UseImm ? b0 : bus.B[i*ELEM_WIDTH +: ELEM_WIDTH];
  end

  vector_alu_lane #(.W(ELEM_WIDTH)) u_lane [LANES-1:0] (
    .a  (a_l),
    .b  (b_l),
    .b0 (b0),
    .op (bus.ALUControl),
    .y  (y_l)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.Result <= '0;
      bus.Zero   <= 1'b1;
    end else begin
      bus.Result <= y_l;
      bus.Zero   <= ~|y_l;
    end
  end
endmodule

// File: tb/tb_vector_alu.sv
// Directed-vector bench for vector_alu: stimulus pushes expected results into a
// scoreboard queue, a negedge monitor pops and compares one cycle later.
module tb_vector_alu;
  localparam int RW = 256;
  localparam int EW = 32;

  typedef struct {
    logic          rst;
    logic [RW-1:0] a;
    logic [RW-1:0] b;
    logic          imm;
    logic [2:0]    op;
    logic [RW-1:0] exp_r;
    string         name;
  } vec_t;

  typedef struct {
    logic [RW-1:0] r;
    logic          z;
    string         name;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  vec_t vecs[$];
  exp_t sb[$];

  vector_alu_if #(.REG_WIDTH(RW), .ELEM_WIDTH(EW)) bus ();

  vector_alu #(.NUM_REGS(8), .REG_WIDTH(RW), .ELEM_WIDTH(EW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  localparam logic [RW-1:0] DEF_A =
    256'h00000001_00000002_00000003_00000004_00000005_00000006_00000007_00000008;
  localparam logic [RW-1:0] DEF_B =
    256'h00000009_00000007_00000006_00000005_00000004_00000003_00000002_00000001;

  function automatic logic [RW-1:0] splat(input logic [EW-1:0] v);
    logic [RW-1:0] r;
    for (int i = 0; i < RW/EW; i++) r[i*EW +: EW] = v;
    return r;
  endfunction

  task automatic add_vec(input string name, input logic r, input logic [RW-1:0] a,
                         input logic [RW-1:0] b, input logic imm, input logic [2:0] op,
                         input logic [RW-1:0] exp_r);
    vec_t v;
    v.name = name; v.rst = r; v.a = a; v.b = b; v.imm = imm; v.op = op; v.exp_r = exp_r;
    vecs.push_back(v);
  endtask

  // Monitor: outputs are registered, so sample mid-cycle.
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      total++;
      if (bus.Result !== e.r) begin
        bad++;
        $display("FAIL %s result: got %h want %h", e.name, bus.Result, e.r);
      end
      total++;
      if (bus.Zero !== e.z) begin
        bad++;
        $display("FAIL %s zero: got %b want %b", e.name, bus.Zero, e.z);
      end
    end
  end

  initial begin
    bus.A = '0; bus.B = '0; bus.UseImm = 1'b0; bus.ALUControl = 3'b000;

    add_vec("reset0", 1'b1, DEF_A, DEF_B, 1'b0, 3'b000, '0);
    add_vec("reset1", 1'b1, DEF_A, DEF_B, 1'b0, 3'b000, '0);
    add_vec("add", 1'b0, DEF_A, DEF_B, 1'b0, 3'b000,
      256'h0000000a_00000009_00000009_00000009_00000009_00000009_00000009_00000009);
    add_vec("sub", 1'b0, DEF_A, DEF_B, 1'b0, 3'b001,
      256'hfffffff8_fffffffb_fffffffd_ffffffff_00000001_00000003_00000005_00000007);
    add_vec("repl", 1'b0, DEF_A, DEF_B, 1'b0, 3'b010, splat(32'h1));
    add_vec("repl_imm", 1'b0, DEF_A, DEF_B, 1'b1, 3'b010, splat(32'h1));
    add_vec("mul", 1'b0, DEF_A, DEF_B, 1'b0, 3'b011,
      256'h00000009_0000000e_00000012_00000014_00000014_00000012_0000000e_00000008);
    add_vec("shl", 1'b0, DEF_A, DEF_B, 1'b0, 3'b100,
      256'h00000200_00000100_000000c0_00000080_00000050_00000030_0000001c_00000010);
    add_vec("slt", 1'b0, DEF_A, DEF_B, 1'b0, 3'b101,
      256'h00000001_00000001_00000001_00000001_00000000_00000000_00000000_00000000);
    add_vec("imm_add", 1'b0, DEF_A, {DEF_B[RW-1:EW], 32'h3}, 1'b1, 3'b000,
      256'h00000004_00000005_00000006_00000007_00000008_00000009_0000000a_0000000b);
    add_vec("zero_sub", 1'b0, '0, '0, 1'b0, 3'b001, '0);
    add_vec("add_ovf", 1'b0, {DEF_A[RW-1:EW], 32'h7fffffff}, DEF_B, 1'b0, 3'b000,
      256'h0000000a_00000009_00000009_00000009_00000009_00000009_00000009_80000000);
    add_vec("add_carry", 1'b0, {DEF_A[RW-1:EW], 32'hffffffff}, DEF_B, 1'b0, 3'b000,
      256'h0000000a_00000009_00000009_00000009_00000009_00000009_00000009_00000000);
    add_vec("slt_sign", 1'b0, {224'h0, 32'h80000000}, {224'h0, 32'h7fffffff}, 1'b0, 3'b101,
      {224'h0, 32'h00000001});
    add_vec("slt_rev", 1'b0, {224'h0, 32'h7fffffff}, {224'h0, 32'h80000000}, 1'b0, 3'b101, '0);
    add_vec("shl_edge", 1'b0, {192'h0, 32'h5, 32'h3}, {192'h0, 32'h20, 32'h1f}, 1'b0, 3'b100,
      {192'h0, 32'h5, 32'h80000000});
    add_vec("mul_wrap", 1'b0, {192'h0, 32'hffffffff, 32'h00010000},
      {192'h0, 32'hffffffff, 32'h00010000}, 1'b0, 3'b011, {192'h0, 32'h1, 32'h0});
    add_vec("op110", 1'b0, DEF_A, DEF_B, 1'b0, 3'b110, '0);
    add_vec("op111", 1'b0, DEF_A, DEF_B, 1'b0, 3'b111, '0);
    add_vec("rst_mul", 1'b1, DEF_A, DEF_B, 1'b0, 3'b011, '0);
    add_vec("mul_after", 1'b0, DEF_A, DEF_B, 1'b0, 3'b011,
      256'h00000009_0000000e_00000012_00000014_00000014_00000012_0000000e_00000008);

    foreach (vecs[k]) begin
      exp_t e;
      @(negedge clk);
      rst = vecs[k].rst;
      bus.A = vecs[k].a;
      bus.B = vecs[k].b;
      bus.UseImm = vecs[k].imm;
      bus.ALUControl = vecs[k].op;
      @(posedge clk);
      e.r = vecs[k].exp_r;
      e.z = (vecs[k].exp_r == '0);
      e.name = vecs[k].name;
      sb.push_back(e);
    end

    begin
      int guard = 0;
      while (sb.size() != 0 && guard < 20) begin
        @(posedge clk);
        guard++;
      end
      if (sb.size() != 0) begin
        total++;
        bad++;
        $display("FAIL drain: got %0d pending want 0", sb.size());
      end
    end
    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
